bin2bcd_serial: RTL

BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

---
 rtl/bin2bcd_serial.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter using shift-and-add-3 (double dabble).
// One input bit is consumed per clock; a result appears WIDTH+1 cycles after start.
module bin2bcd_serial #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  // Scratch is sized for the input width so overflow can be detected for any DIGITS.
  localparam int unsigned SD    = (WIDTH + 2) / 3;
  localparam int unsigned SW    = 4 * SD;
  localparam int unsigned EXT_D = (SD > DIGITS) ? SD : DIGITS;
  localparam int unsigned EW    = 4 * EXT_D;
  localparam int unsigned OW    = 4 * DIGITS;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mag_q;
  logic [SW-1:0]    scratch_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;

  logic [SW-1:0]    adj_c;
  logic [EW-1:0]    ext_c;
  logic [EW-1:0]    hi_c;
  logic             ovf_c;
  logic             neg_in_c;
  logic [WIDTH-1:0] mag_in_c;

  // Input magnitude and sign; the most negative value maps onto itself as an unsigned magnitude.
  always_comb begin
    neg_in_c = signed_mode & bin_in[WIDTH-1];
    mag_in_c = neg_in_c ? WIDTH'(-bin_in) : bin_in;
  end

  // Add-3 correction of every scratch digit that is 5 or more before the next shift.
  always_comb begin
    adj_c = '0;
    for (int i = 0; i < int'(SD); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end else begin
        adj_c[4*i +: 4] = scratch_q[4*i +: 4];
      end
    end
  end

  // Result view: zero-extended scratch, with any digit above the output width flagging overflow.
  always_comb begin
    ext_c = EW'(scratch_q);
    hi_c  = ext_c >> OW;
    ovf_c = |hi_c;
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      bcd_out   <= '0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_q     <= mag_in_c;
            sign_q    <= neg_in_c;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= SW'({adj_c, mag_q[WIDTH-1]});
          mag_q     <= mag_q << 1;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bcd_out  <= ovf_c ? {DIGITS{4'h9}} : ext_c[OW-1:0];
          overflow <= ovf_c;
          negative <= sign_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
